// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: datapath widths, ALU op codes,
// forward-select codes, FSM state encoding, the control bundle carried to
// EX/MEM, and the operand forwarding mux.
package exec_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned PC_W       = 5;
  localparam int unsigned MUL_CYCLES = DATA_W;
  localparam int unsigned OP_W       = 4;
  localparam int unsigned FWD_W      = 2;
  localparam int unsigned SHAMT_W    = $clog2(DATA_W);
  localparam int unsigned CNT_W      = $clog2(MUL_CYCLES);

  localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [OP_W-1:0] ALU_NOR  = 4'd5;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'd6;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'd7;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'd8;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'd9;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'd10;
  localparam logic [OP_W-1:0] ALU_LUI  = 4'd11;
  localparam logic [OP_W-1:0] ALU_MUL  = 4'd12;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } exec_state_t;

  // Control bits that travel with an instruction into EX/MEM.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic jal;
  } ctrl_t;

  // Operand forwarding; code 11 falls back to the register-file value.
  function automatic logic [DATA_W-1:0] fwd_mux(
    input logic [FWD_W-1:0]  sel,
    input logic [DATA_W-1:0] rf,
    input logic [DATA_W-1:0] wb,
    input logic [DATA_W-1:0] mem
  );
    case (sel)
      FWD_WB:  return wb;
      FWD_MEM: return mem;
      default: return rf;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX -> EX/MEM bus of the execute stage.
//   master: pipeline side driving ID/EX operands/control and forward sources,
//           receiving stall_E and the registered EX/MEM (_M) fields.
//   slave : the execute stage itself.
interface execute_stage_if;
  import exec_pkg::*;

  logic                  Flush_E;
  logic                  RegWrite_E, MemRead_E, MemWrite_E, MemToReg_E, JumpAndLink_E;
  logic [OP_W-1:0]       AluOp_E;
  logic                  AluSrc_E;
  logic [DATA_W-1:0]     ReadData1_E, ReadData2_E, Imm_E;
  logic [REG_W-1:0]      RegisterD_E;
  logic [PC_W-1:0]       Pc_E;
  logic [FWD_W-1:0]      ForwardA_E, ForwardB_E;
  logic [DATA_W-1:0]     ALU_Result_Mout, WriteData_W;

  logic                  stall_E;
  logic                  RegWrite_M, MemRead_M, MemWrite_M, MemToReg_M, JumpAndLink_M;
  logic [DATA_W-1:0]     AluResult_M, ReadData2_M;
  logic [REG_W-1:0]      RegisterD_M;
  logic [PC_W-1:0]       Pc_M;

  modport master (
    output Flush_E, RegWrite_E, MemRead_E, MemWrite_E, MemToReg_E, JumpAndLink_E,
           AluOp_E, AluSrc_E, ReadData1_E, ReadData2_E, Imm_E, RegisterD_E, Pc_E,
           ForwardA_E, ForwardB_E, ALU_Result_Mout, WriteData_W,
    input  stall_E, RegWrite_M, MemRead_M, MemWrite_M, MemToReg_M, JumpAndLink_M,
           AluResult_M, ReadData2_M, RegisterD_M, Pc_M
  );

  modport slave (
    input  Flush_E, RegWrite_E, MemRead_E, MemWrite_E, MemToReg_E, JumpAndLink_E,
           AluOp_E, AluSrc_E, ReadData1_E, ReadData2_E, Imm_E, RegisterD_E, Pc_E,
           ForwardA_E, ForwardB_E, ALU_Result_Mout, WriteData_W,
    output stall_E, RegWrite_M, MemRead_M, MemWrite_M, MemToReg_M, JumpAndLink_M,
           AluResult_M, ReadData2_M, RegisterD_M, Pc_M
  );

endinterface

// File: rtl/execute_stage_iter_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, low DATA_W
// bits of the product kept.
//   clk, reset : clock, synchronous active-high reset
//   start      : load operands and begin (ignored while abort is high)
//   abort      : stop immediately, result discarded
//   a, b       : multiplicand, multiplier
//   done_c     : combinational, high during the final step cycle
//   product    : accumulator; valid the cycle after done_c
module iter_multiplier
  import exec_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done_c,
  output logic [DATA_W-1:0] product
);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              busy;

  assign done_c  = busy && (cnt == CNT_W'(MUL_CYCLES - 1));
  assign product = acc;

  // Shift-add step: add shifted multiplicand when the current multiplier bit is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (abort) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done_c) begin
        cnt  <= '0;
        busy <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, store-data forwarding and the
// EX/MEM register. MUL runs on an iterative multiplier; while it runs the
// stage stalls upstream and pushes bubbles into EX/MEM.
//   clk, reset : clock, synchronous active-high reset
//   bus        : execute_stage_if.slave (ID/EX inputs, forward sources,
//                stall_E, registered _M outputs)
module execute_stage
  import exec_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  execute_stage_if.slave bus
);

  exec_state_t        state;
  logic [DATA_W-1:0]  fwd_a, fwd_b, op_b, alu_res;
  logic [SHAMT_W-1:0] shamt;
  logic               mul_start_c, mul_done_c, stall_c;
  logic [DATA_W-1:0]  mul_product;
  ctrl_t              ctrl_e;

  // Held copy of the MUL instruction's non-operand fields.
  ctrl_t              mul_ctrl;
  logic [REG_W-1:0]   mul_rd;
  logic [PC_W-1:0]    mul_pc;
  logic [DATA_W-1:0]  mul_store;

  // EX/MEM register.
  ctrl_t              ctrl_m;
  logic [DATA_W-1:0]  result_m, store_m;
  logic [REG_W-1:0]   rd_m;
  logic [PC_W-1:0]    pc_m;

  assign ctrl_e = '{reg_write:  bus.RegWrite_E,
                    mem_read:   bus.MemRead_E,
                    mem_write:  bus.MemWrite_E,
                    mem_to_reg: bus.MemToReg_E,
                    jal:        bus.JumpAndLink_E};

  assign fwd_a = fwd_mux(bus.ForwardA_E, bus.ReadData1_E, bus.WriteData_W, bus.ALU_Result_Mout);
  assign fwd_b = fwd_mux(bus.ForwardB_E, bus.ReadData2_E, bus.WriteData_W, bus.ALU_Result_Mout);
  assign op_b  = bus.AluSrc_E ? bus.Imm_E : fwd_b;
  assign shamt = op_b[SHAMT_W-1:0];

  // Single-cycle ALU; MUL and undefined codes yield 0 here.
  always_comb begin
    alu_res = '0;
    case (bus.AluOp_E)
      ALU_ADD:  alu_res = fwd_a + op_b;
      ALU_SUB:  alu_res = fwd_a - op_b;
      ALU_AND:  alu_res = fwd_a & op_b;
      ALU_OR:   alu_res = fwd_a | op_b;
      ALU_XOR:  alu_res = fwd_a ^ op_b;
      ALU_NOR:  alu_res = ~(fwd_a | op_b);
      ALU_SLT:  alu_res = DATA_W'($signed(fwd_a) < $signed(op_b));
      ALU_SLTU: alu_res = DATA_W'(fwd_a < op_b);
      ALU_SLL:  alu_res = fwd_a << shamt;
      ALU_SRL:  alu_res = fwd_a >> shamt;
      ALU_SRA:  alu_res = DATA_W'($signed(fwd_a) >>> shamt);
      ALU_LUI:  alu_res = op_b << 16;
      default:  alu_res = '0;
    endcase
  end

  assign mul_start_c = (state == ST_IDLE) && (bus.AluOp_E == ALU_MUL) && !bus.Flush_E;

  // Hold upstream from MUL acceptance through the last BUSY cycle; a flush releases it at once.
  always_comb begin
    stall_c = 1'b0;
    case (state)
      ST_IDLE: stall_c = mul_start_c;
      ST_BUSY: stall_c = !bus.Flush_E;
      default: stall_c = 1'b0;
    endcase
    if (reset) stall_c = 1'b0;
  end

  iter_multiplier u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start_c),
    .abort   (bus.Flush_E),
    .a       (fwd_a),
    .b       (fwd_b),
    .done_c  (mul_done_c),
    .product (mul_product)
  );

  // FSM, MUL control latch and EX/MEM register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mul_ctrl  <= '0;
      mul_rd    <= '0;
      mul_pc    <= '0;
      mul_store <= '0;
      ctrl_m    <= '0;
      result_m  <= '0;
      store_m   <= '0;
      rd_m      <= '0;
      pc_m      <= '0;
    end else begin
      // Bubble unless a branch below loads a real instruction.
      ctrl_m   <= '0;
      result_m <= '0;
      store_m  <= '0;
      rd_m     <= '0;
      pc_m     <= '0;
      case (state)
        ST_IDLE: begin
          if (mul_start_c) begin
            mul_ctrl  <= ctrl_e;
            mul_rd    <= bus.RegisterD_E;
            mul_pc    <= bus.Pc_E;
            mul_store <= fwd_b;
            state     <= ST_BUSY;
          end else if (!bus.Flush_E) begin
            ctrl_m   <= ctrl_e;
            result_m <= alu_res;
            store_m  <= fwd_b;
            rd_m     <= bus.RegisterD_E;
            pc_m     <= bus.Pc_E;
          end
        end
        ST_BUSY: begin
          if (bus.Flush_E)     state <= ST_IDLE;
          else if (mul_done_c) state <= ST_DONE;
        end
        ST_DONE: begin
          if (!bus.Flush_E) begin
            ctrl_m   <= mul_ctrl;
            result_m <= mul_product;
            store_m  <= mul_store;
            rd_m     <= mul_rd;
            pc_m     <= mul_pc;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.stall_E       = stall_c;
  assign bus.RegWrite_M    = ctrl_m.reg_write;
  assign bus.MemRead_M     = ctrl_m.mem_read;
  assign bus.MemWrite_M    = ctrl_m.mem_write;
  assign bus.MemToReg_M    = ctrl_m.mem_to_reg;
  assign bus.JumpAndLink_M = ctrl_m.jal;
  assign bus.AluResult_M   = result_m;
  assign bus.ReadData2_M   = store_m;
  assign bus.RegisterD_M   = rd_m;
  assign bus.Pc_M          = pc_m;

endmodule
